// File: rtl/mips_mmio_pkg.sv
// Shared definitions for the data-memory MMIO responder: register window
// offsets, CTRL/STATUS bit positions and the timer state encoding.
package mips_mmio_pkg;

    localparam logic [4:0] OFF_GPO    = 5'h00;
    localparam logic [4:0] OFF_GPI    = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_LOAD   = 5'h0C;
    localparam logic [4:0] OFF_COUNT  = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h14;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int STAT_EXPIRED = 0;

    typedef enum logic [1:0] {
        TMR_IDLE    = 2'd0,
        TMR_RUN     = 2'd1,
        TMR_EXPIRED = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer with one-shot / auto-reload modes, sticky expiry flag
// (write-1-to-clear) and a level interrupt.
module mmio_timer
    import mips_mmio_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_load,
    input  logic        i_wr_status,
    input  logic [31:0] i_wdata,
    output logic [2:0]  o_ctrl,
    output logic [31:0] o_load,
    output logic [31:0] o_count,
    output logic        o_expired,
    output logic        o_irq
);

    tmr_state_e  r_state;
    tmr_state_e  w_state_nxt;
    logic [2:0]  r_ctrl;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic [31:0] w_count_nxt;
    logic        r_status;
    logic        w_status_nxt;
    logic        w_expire;
    logic        w_en_wr1;
    logic        w_en_wr0;

    assign w_en_wr1 = i_wr_ctrl &  i_wdata[CTRL_EN];
    assign w_en_wr0 = i_wr_ctrl & ~i_wdata[CTRL_EN];

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_expire    = 1'b0;
        // Disabling wins over everything, including a same-cycle expiry.
        if (w_en_wr0) begin
            w_state_nxt = TMR_IDLE;
        end else begin
            case (r_state)
                TMR_IDLE: begin
                    if (w_en_wr1) begin
                        w_count_nxt = r_load;
                        w_state_nxt = TMR_RUN;
                    end
                end
                TMR_RUN: begin
                    if (r_count != 32'd0) begin
                        w_count_nxt = r_count - 32'd1;
                    end else begin
                        w_expire = 1'b1;
                        if (r_ctrl[CTRL_AUTO]) begin
                            w_count_nxt = r_load;
                        end else begin
                            w_state_nxt = TMR_EXPIRED;
                        end
                    end
                end
                TMR_EXPIRED: begin
                    if (w_en_wr1) begin
                        w_count_nxt = r_load;
                        w_state_nxt = TMR_RUN;
                    end
                end
                default: w_state_nxt = TMR_IDLE;
            endcase
        end
    end

    assign w_status_nxt = w_expire | (r_status & ~(i_wr_status & i_wdata[STAT_EXPIRED]));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= TMR_IDLE;
            r_ctrl   <= 3'd0;
            r_load   <= 32'd0;
            r_count  <= 32'd0;
            r_status <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_status <= w_status_nxt;
            if (i_wr_ctrl) begin
                r_ctrl <= i_wdata[2:0];
            end
            if (i_wr_load) begin
                r_load <= i_wdata;
            end
        end
    end

    assign o_ctrl    = r_ctrl;
    assign o_load    = r_load;
    assign o_count   = r_count;
    assign o_expired = r_status;
    assign o_irq     = r_status & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the core's MEM stage: word RAM at the bottom of
// the address space plus a small register window (GPO, GPI, timer).
module dmem_mmio_responder
    import mips_mmio_pkg::*;
#(
    parameter int          RAM_WORDS = 64,
    parameter int          GPIO_W    = 32,
    parameter logic [31:0] MMIO_BASE = 32'h800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_dm,
    input  logic [31:0]       addr,
    input  logic [31:0]       wd_dm,
    output logic [31:0]       rd_dm,
    input  logic [GPIO_W-1:0] gpi,
    output logic [GPIO_W-1:0] gpo,
    output logic              irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    logic [31:0]       r_ram [RAM_WORDS];
    logic [GPIO_W-1:0] r_gpo;
    logic [GPIO_W-1:0] r_gpi_s1;
    logic [GPIO_W-1:0] r_gpi_s2;

    logic [29:0]       w_word_off;
    logic [4:0]        w_slot;
    logic              w_is_ram;
    logic              w_mmio;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr_gpo;
    logic              w_wr_ctrl;
    logic              w_wr_load;
    logic              w_wr_status;
    logic [2:0]        w_ctrl;
    logic [31:0]       w_load;
    logic [31:0]       w_count;
    logic              w_expired;
    logic [31:0]       w_gpo_ext;
    logic [31:0]       w_gpi_ext;
    logic [31:0]       w_rd;
    logic              w_unused;

    // Decode on word addresses; the byte lane bits never select anything.
    assign w_word_off = addr[31:2] - MMIO_BASE[31:2];
    assign w_slot     = {w_word_off[2:0], 2'b00};
    assign w_is_ram   = (addr[31:RAM_AW+2] == '0);
    assign w_mmio     = ~w_is_ram && (addr[31:2] >= MMIO_BASE[31:2]) && (w_word_off[29:3] == '0);
    assign w_ram_idx  = addr[RAM_AW+1:2];
    assign w_unused   = ^addr[1:0];

    assign w_wr_gpo    = we_dm & w_mmio & (w_slot == OFF_GPO);
    assign w_wr_ctrl   = we_dm & w_mmio & (w_slot == OFF_CTRL);
    assign w_wr_load   = we_dm & w_mmio & (w_slot == OFF_LOAD);
    assign w_wr_status = we_dm & w_mmio & (w_slot == OFF_STATUS);

    always_ff @(posedge clk) begin
        if (we_dm && w_is_ram) begin
            r_ram[w_ram_idx] <= wd_dm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gpo    <= '0;
            r_gpi_s1 <= '0;
            r_gpi_s2 <= '0;
        end else begin
            r_gpi_s1 <= gpi;
            r_gpi_s2 <= r_gpi_s1;
            if (w_wr_gpo) begin
                r_gpo <= wd_dm[GPIO_W-1:0];
            end
        end
    end

    mmio_timer u_timer (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_wr_ctrl   (w_wr_ctrl),
        .i_wr_load   (w_wr_load),
        .i_wr_status (w_wr_status),
        .i_wdata     (wd_dm),
        .o_ctrl      (w_ctrl),
        .o_load      (w_load),
        .o_count     (w_count),
        .o_expired   (w_expired),
        .o_irq       (irq)
    );

    always_comb begin
        w_gpo_ext = '0;
        w_gpi_ext = '0;
        w_gpo_ext[GPIO_W-1:0] = r_gpo;
        w_gpi_ext[GPIO_W-1:0] = r_gpi_s2;
    end

    always_comb begin
        w_rd = '0;
        if (w_is_ram) begin
            w_rd = r_ram[w_ram_idx];
        end else if (w_mmio) begin
            case (w_slot)
                OFF_GPO:    w_rd = w_gpo_ext;
                OFF_GPI:    w_rd = w_gpi_ext;
                OFF_CTRL:   w_rd = {29'd0, w_ctrl};
                OFF_LOAD:   w_rd = w_load;
                OFF_COUNT:  w_rd = w_count;
                OFF_STATUS: w_rd = {31'd0, w_expired};
                default:    w_rd = '0;
            endcase
        end
    end

    assign rd_dm = w_rd;
    assign gpo   = r_gpo;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, GPIO, timer modes and async reset.
module tb_dmem_mmio_responder;

    localparam logic [31:0] A_GPO    = 32'h800;
    localparam logic [31:0] A_GPI    = 32'h804;
    localparam logic [31:0] A_CTRL   = 32'h808;
    localparam logic [31:0] A_LOAD   = 32'h80C;
    localparam logic [31:0] A_COUNT  = 32'h810;
    localparam logic [31:0] A_STATUS = 32'h814;

    logic        clk;
    logic        rst;
    logic        we_dm;
    logic [31:0] addr;
    logic [31:0] wd_dm;
    logic [31:0] rd_dm;
    logic [31:0] gpi;
    logic [31:0] gpo;
    logic        irq;

    int n_chk;
    int n_pass;

    dmem_mmio_responder #(
        .RAM_WORDS (64),
        .GPIO_W    (32),
        .MMIO_BASE (32'h800)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we_dm (we_dm),
        .addr  (addr),
        .wd_dm (wd_dm),
        .rd_dm (rd_dm),
        .gpi   (gpi),
        .gpo   (gpo),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we_dm = 1'b1;
        addr  = a;
        wd_dm = d;
        @(negedge clk);
        we_dm = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        we_dm = 1'b0;
        addr  = a;
        #1;
        check(tag, rd_dm, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        we_dm  = 1'b0;
        addr   = 32'h0;
        wd_dm  = 32'h0;
        gpi    = 32'h11;

        // Reset state
        @(negedge clk);
        check("rst_gpo", gpo, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        chk_rd("rst_count", A_COUNT, 32'h0);
        chk_rd("rst_ctrl", A_CTRL, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // RAM
        wr(32'h010, 32'hDEADBEEF);
        chk_rd("ram_rd", 32'h010, 32'hDEADBEEF);
        chk_rd("ram_rd_unaligned", 32'h013, 32'hDEADBEEF);
        chk_rd("unmapped_rd", 32'h7F0, 32'h0);
        wr(32'h000, 32'h0000_1111);
        wr(32'h0FC, 32'hCAFE_F00D);
        wr(32'h100, 32'hBAD0_BAD0);
        chk_rd("ram_top", 32'h0FC, 32'hCAFE_F00D);
        chk_rd("ram_no_alias", 32'h000, 32'h0000_1111);
        chk_rd("beyond_ram", 32'h100, 32'h0);
        we_dm = 1'b1;
        addr  = 32'h010;
        wd_dm = 32'h1234_5678;
        #1;
        check("ram_rdw_old", rd_dm, 32'hDEADBEEF);
        @(negedge clk);
        chk_rd("ram_rdw_new", 32'h010, 32'h1234_5678);

        // GPIO
        wr(A_GPO, 32'hA5);
        check("gpo_pin", gpo, 32'hA5);
        chk_rd("gpo_rd", A_GPO, 32'hA5);
        gpi = 32'h3C;
        chk_rd("gpi_0edge", A_GPI, 32'h11);
        @(negedge clk);
        chk_rd("gpi_1edge", A_GPI, 32'h11);
        @(negedge clk);
        chk_rd("gpi_2edge", A_GPI, 32'h3C);
        wr(A_GPI, 32'hFFFF);
        chk_rd("gpi_ro", A_GPI, 32'h3C);

        // One-shot timer with irq
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'h5);
        chk_rd("os_cnt3", A_COUNT, 32'd3);
        @(negedge clk);
        chk_rd("os_cnt2", A_COUNT, 32'd2);
        @(negedge clk);
        chk_rd("os_cnt1", A_COUNT, 32'd1);
        @(negedge clk);
        chk_rd("os_cnt0", A_COUNT, 32'd0);
        chk_rd("os_st_pre", A_STATUS, 32'd0);
        check("os_irq_pre", 32'(irq), 32'd0);
        @(negedge clk);
        chk_rd("os_st_exp", A_STATUS, 32'd1);
        check("os_irq_exp", 32'(irq), 32'd1);
        chk_rd("os_cnt_exp", A_COUNT, 32'd0);
        @(negedge clk);
        chk_rd("os_cnt_hold", A_COUNT, 32'd0);
        wr(A_STATUS, 32'd1);
        chk_rd("os_st_clr", A_STATUS, 32'd0);
        check("os_irq_clr", 32'(irq), 32'd0);
        wr(A_CTRL, 32'h0);

        // Auto-reload, W1C vs expiry
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'h3);
        chk_rd("ar_cnt2", A_COUNT, 32'd2);
        @(negedge clk);
        @(negedge clk);
        chk_rd("ar_cnt0", A_COUNT, 32'd0);
        chk_rd("ar_st0", A_STATUS, 32'd0);
        @(negedge clk);
        chk_rd("ar_st_exp", A_STATUS, 32'd1);
        chk_rd("ar_reload", A_COUNT, 32'd2);
        check("ar_irq_masked", 32'(irq), 32'd0);
        wr(A_STATUS, 32'd1);
        chk_rd("ar_clr", A_STATUS, 32'd0);
        chk_rd("ar_cnt1", A_COUNT, 32'd1);
        @(negedge clk);
        wr(A_STATUS, 32'd1);
        chk_rd("ar_set_wins", A_STATUS, 32'd1);
        chk_rd("ar_reload2", A_COUNT, 32'd2);

        // LOAD change mid-run, then disable
        wr(A_LOAD, 32'd10);
        chk_rd("ld_cur_unaff", A_COUNT, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk_rd("ld_next_reload", A_COUNT, 32'd10);
        wr(A_STATUS, 32'd1);
        chk_rd("ld_cnt9", A_COUNT, 32'd9);
        wr(A_CTRL, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_rd("dis_freeze", A_COUNT, 32'd9);
        chk_rd("dis_no_exp", A_STATUS, 32'd0);
        wr(A_COUNT, 32'h55);
        chk_rd("count_ro", A_COUNT, 32'd9);
        wr(A_CTRL, 32'hFFFF_FFF0);
        chk_rd("ctrl_unused_bits", A_CTRL, 32'h0);

        // LOAD=0 expires one cycle after start; restart from EXPIRED
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'h5);
        chk_rd("l0_st_pre", A_STATUS, 32'd0);
        @(negedge clk);
        check("l0_irq", 32'(irq), 32'd1);
        wr(A_STATUS, 32'd1);
        check("l0_irq_clr", 32'(irq), 32'd0);
        wr(A_LOAD, 32'd1);
        wr(A_CTRL, 32'h5);
        chk_rd("restart_cnt", A_COUNT, 32'd1);
        wr(A_CTRL, 32'h0);

        // Async reset mid-count
        wr(A_GPO, 32'h5A);
        wr(A_LOAD, 32'd5);
        wr(A_CTRL, 32'h7);
        repeat (7) @(negedge clk);
        chk_rd("pre_rst_cnt", A_COUNT, 32'd4);
        check("pre_rst_irq", 32'(irq), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_gpo", gpo, 32'h0);
        check("arst_irq", 32'(irq), 32'd0);
        chk_rd("arst_cnt", A_COUNT, 32'd0);
        chk_rd("arst_st", A_STATUS, 32'd0);
        we_dm = 1'b1;
        addr  = A_GPO;
        wd_dm = 32'hFF;
        @(negedge clk);
        check("rst_gpo_drop", gpo, 32'h0);
        chk_rd("rst_cnt_hold", A_COUNT, 32'd0);
        rst = 1'b1;
        wr(A_GPO, 32'h77);
        check("post_rst_gpo", gpo, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
